// File: rtl/dma_read_arbiter.sv
// Two-requester round-robin arbiter in front of a single DMA read channel.
// Latches the winner's burst descriptor, launches it, and routes returned beats to the owner.
module dma_read_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [LEN_W-1:0]  a_len,
    input  logic [LEN_W-1:0]  b_len,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic              a_rlast,
    output logic              b_rlast,
    output logic [DATA_W-1:0] rdata,
    output logic              dma_start,
    output logic [ADDR_W-1:0] dma_addr,
    output logic [LEN_W-1:0]  dma_len,
    input  logic              dma_rvalid,
    input  logic              dma_rlast,
    input  logic [DATA_W-1:0] dma_rdata,
    output logic              busy,
    output logic              owner,
    output logic              err,
    input  logic              err_clr
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER
    } state_t;

    localparam logic [LEN_W:0] CNT_ONE = (LEN_W + 1)'(1);

    state_t              state_q;
    logic                last_q;   // requester served last: 0=A, 1=B
    logic                owner_q;
    logic                start_q;
    logic                a_gnt_q;
    logic                b_gnt_q;
    logic                err_q;
    logic                err_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W:0]      cnt_q;

    logic                in_xfer;
    logic                win_b;
    logic                bad_last;
    logic                overrun;
    logic                stray;
    logic [LEN_W:0]      len_ext;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        in_xfer  = 1'b0;
        win_b    = 1'b0;
        len_ext  = '0;
        bad_last = 1'b0;
        overrun  = 1'b0;
        stray    = 1'b0;
        err_d    = err_q;

        in_xfer  = (state_q == XFER);
        win_b    = (a_req && b_req) ? !last_q : b_req;
        len_ext  = {1'b0, len_q};
        bad_last = in_xfer && dma_rvalid && dma_rlast && (cnt_q != len_ext);
        overrun  = in_xfer && dma_rvalid && !dma_rlast && (cnt_q >= len_ext);
        stray    = dma_rvalid && !in_xfer;
        // A fresh error outranks a simultaneous clear.
        err_d    = (err_q && !err_clr) || bad_last || overrun || stray;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            start_q <= 1'b0;
            a_gnt_q <= 1'b0;
            b_gnt_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            start_q <= 1'b0;
            a_gnt_q <= 1'b0;
            b_gnt_q <= 1'b0;
            err_q   <= err_d;
            case (state_q)
                IDLE: begin
                    if (a_req || b_req) begin
                        owner_q <= win_b;
                        addr_q  <= win_b ? b_addr : a_addr;
                        len_q   <= win_b ? b_len : a_len;
                        start_q <= 1'b1;
                        a_gnt_q <= !win_b;
                        b_gnt_q <= win_b;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= XFER;
                end
                XFER: begin
                    // Only rlast ends a burst, even after a length error.
                    if (dma_rvalid) begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (dma_rlast) begin
                            last_q  <= owner_q;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_gnt     = a_gnt_q;
    assign b_gnt     = b_gnt_q;
    assign dma_start = start_q;
    assign dma_addr  = addr_q;
    assign dma_len   = len_q;
    assign owner     = owner_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign rdata     = dma_rdata;
    assign a_rvalid  = in_xfer && dma_rvalid && !owner_q;
    assign b_rvalid  = in_xfer && dma_rvalid && owner_q;
    assign a_rlast   = in_xfer && dma_rvalid && dma_rlast && !owner_q;
    assign b_rlast   = in_xfer && dma_rvalid && dma_rlast && owner_q;

endmodule

// File: tb/tb_dma_read_arbiter.sv
// Directed bench for dma_read_arbiter: arbitration order, beat routing, error flag and reset abort.
module tb_dma_read_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              a_req = 1'b0;
    logic              b_req = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [LEN_W-1:0]  a_len = '0;
    logic [LEN_W-1:0]  b_len = '0;
    logic              a_gnt;
    logic              b_gnt;
    logic              a_rvalid;
    logic              b_rvalid;
    logic              a_rlast;
    logic              b_rlast;
    logic [DATA_W-1:0] rdata;
    logic              dma_start;
    logic [ADDR_W-1:0] dma_addr;
    logic [LEN_W-1:0]  dma_len;
    logic              dma_rvalid = 1'b0;
    logic              dma_rlast = 1'b0;
    logic [DATA_W-1:0] dma_rdata = '0;
    logic              busy;
    logic              owner;
    logic              err;
    logic              err_clr = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    dma_read_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .b_req     (b_req),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .a_len     (a_len),
        .b_len     (b_len),
        .a_gnt     (a_gnt),
        .b_gnt     (b_gnt),
        .a_rvalid  (a_rvalid),
        .b_rvalid  (b_rvalid),
        .a_rlast   (a_rlast),
        .b_rlast   (b_rlast),
        .rdata     (rdata),
        .dma_start (dma_start),
        .dma_addr  (dma_addr),
        .dma_len   (dma_len),
        .dma_rvalid(dma_rvalid),
        .dma_rlast (dma_rlast),
        .dma_rdata (dma_rdata),
        .busy      (busy),
        .owner     (owner),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n beats; beat last_idx carries rlast; every beat must route to requester to_b only.
    task automatic beats(input int n, input int last_idx, input logic to_b);
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            w          = 32'hC0DE_0000 + 32'(i);
            dma_rvalid = 1'b1;
            dma_rlast  = (i == last_idx);
            dma_rdata  = {8{w}};
            #1;
            check("a_rvalid", a_rvalid, !to_b);
            check("b_rvalid", b_rvalid, to_b);
            check("a_rlast", a_rlast, !to_b && (i == last_idx));
            check("b_rlast", b_rlast, to_b && (i == last_idx));
            check("rdata", rdata, {8{w}});
            tick();
        end
        dma_rvalid = 1'b0;
        dma_rlast  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_owner", owner, 1'b0);
        check("rst_start", dma_start, 1'b0);
        check("rst_gnt", {a_gnt, b_gnt}, 2'b00);
        check("rst_addr", dma_addr, 32'h0);
        check("rst_len", dma_len, 8'h0);
        check("rst_err", err, 1'b0);

        // Contention after reset: A first (4 beats), then B (2 beats)
        rst    = 1'b0;
        a_req  = 1'b1;
        b_req  = 1'b1;
        a_addr = 32'h0000_0100;
        a_len  = 8'd3;
        b_addr = 32'h0000_0200;
        b_len  = 8'd1;
        tick();
        check("c1_gnt", {a_gnt, b_gnt}, 2'b10);
        check("c1_start", dma_start, 1'b1);
        check("c1_addr", dma_addr, 32'h0000_0100);
        check("c1_len", dma_len, 8'd3);
        check("c1_owner", owner, 1'b0);
        a_req = 1'b0;
        tick();
        check("c1_start_pulse", dma_start, 1'b0);
        check("c1_gnt_pulse", {a_gnt, b_gnt}, 2'b00);
        check("c1_busy", busy, 1'b1);
        beats(4, 3, 1'b0);
        check("c1_idle", busy, 1'b0);
        tick();
        check("c1_bgnt", {a_gnt, b_gnt}, 2'b01);
        check("c1_bowner", owner, 1'b1);
        check("c1_baddr", dma_addr, 32'h0000_0200);
        check("c1_blen", dma_len, 8'd1);
        b_req = 1'b0;
        tick();
        beats(2, 1, 1'b1);
        check("c1_err", err, 1'b0);
        check("c1_done", busy, 1'b0);

        // Both held high: grants alternate A,B,A,B,A,B
        a_req = 1'b1;
        b_req = 1'b1;
        a_len = 8'd0;
        b_len = 8'd0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("rr_gnt%0d", k), {a_gnt, b_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            beats(1, 0, (k % 2) == 1);
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check("rr_err", err, 1'b0);

        // Lone B request with len 0; a request withdrawn before grant leaves no trace
        b_req  = 1'b1;
        b_addr = 32'h0000_1000;
        b_len  = 8'd0;
        tick();
        check("b_start", dma_start, 1'b1);
        check("b_gnt", {a_gnt, b_gnt}, 2'b01);
        check("b_addr", dma_addr, 32'h0000_1000);
        check("b_len", dma_len, 8'd0);
        check("b_owner", owner, 1'b1);
        b_req = 1'b0;
        tick();
        a_req = 1'b1;
        beats(1, 0, 1'b1);
        a_req = 1'b0;
        check("b_idle", busy, 1'b0);
        tick();
        check("wd_gnt", {a_gnt, b_gnt}, 2'b00);
        check("wd_busy", busy, 1'b0);

        // Early rlast: len 3, rlast on beat 1
        a_req  = 1'b1;
        a_addr = 32'h0000_2000;
        a_len  = 8'd3;
        tick();
        check("el_gnt", {a_gnt, b_gnt}, 2'b10);
        check("el_len", dma_len, 8'd3);
        a_req = 1'b0;
        tick();
        beats(2, 1, 1'b0);
        check("el_err", err, 1'b1);
        check("el_idle", busy, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("el_clr", err, 1'b0);

        // Stray beat in IDLE, then clear colliding with another stray beat
        dma_rvalid = 1'b1;
        dma_rlast  = 1'b1;
        #1;
        check("st_route", {a_rvalid, b_rvalid, a_rlast, b_rlast}, 4'b0000);
        tick();
        check("st_err", err, 1'b1);
        check("st_busy", busy, 1'b0);
        err_clr = 1'b1;
        tick();
        check("st_clr_collide", err, 1'b1);
        dma_rvalid = 1'b0;
        dma_rlast  = 1'b0;
        tick();
        err_clr = 1'b0;
        check("st_clr", err, 1'b0);

        // Overrun: len 1, no rlast on beat 1; burst still ends only on rlast
        a_req = 1'b1;
        a_len = 8'd1;
        tick();
        check("ov_gnt", {a_gnt, b_gnt}, 2'b10);
        a_req = 1'b0;
        tick();
        beats(2, -1, 1'b0);
        check("ov_err", err, 1'b1);
        check("ov_busy", busy, 1'b1);
        beats(1, 0, 1'b0);
        check("ov_idle", busy, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ov_clr", err, 1'b0);

        // A served last, so B wins; reset mid-XFER aborts and restores A priority
        a_req  = 1'b1;
        b_req  = 1'b1;
        b_addr = 32'h0000_3000;
        b_len  = 8'd3;
        tick();
        check("ra_gnt", {a_gnt, b_gnt}, 2'b01);
        tick();
        beats(1, -1, 1'b1);
        rst        = 1'b1;
        dma_rvalid = 1'b1;
        tick();
        check("ra_busy", busy, 1'b0);
        check("ra_owner", owner, 1'b0);
        check("ra_err", err, 1'b0);
        check("ra_addr", dma_addr, 32'h0);
        check("ra_route", {a_rvalid, b_rvalid}, 2'b00);
        rst        = 1'b0;
        dma_rvalid = 1'b0;
        tick();
        check("ra_agnt", {a_gnt, b_gnt}, 2'b10);
        check("ra_err2", err, 1'b0);
        a_req = 1'b0;
        b_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dma_read_arbiter.md
DMA_READ_ARBITER -- requirements
Module: dma_read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, DMA byte-address width.
REQ-002 SHALL have parameter DATA_W, default 256, DMA read-beat width.
REQ-003 SHALL have parameter LEN_W, default 8, burst-length field width (beats minus 1).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports a_req/b_req  input  1  requester A/B burst request, level, held until grant.
REQ-007 SHALL have ports a_addr/b_addr  input  ADDR_W  requester burst start address.
REQ-008 SHALL have ports a_len/b_len  input  LEN_W  requester burst length minus 1.
REQ-009 SHALL have ports a_gnt/b_gnt  output  1  one-cycle grant pulse.
REQ-010 SHALL have ports a_rvalid/b_rvalid  output  1  read beat valid for the owning requester.
REQ-011 SHALL have ports a_rlast/b_rlast  output  1  last beat for the owning requester.
REQ-012 SHALL have port rdata  output  DATA_W  shared read data, combinational copy of dma_rdata.
REQ-013 SHALL have port dma_start  output  1  one-cycle burst launch pulse to DMA.
REQ-014 SHALL have ports dma_addr/dma_len  output  ADDR_W/LEN_W  registered burst descriptor.
REQ-015 SHALL have ports dma_rvalid/dma_rlast  input  1  DMA read beat valid / last beat.
REQ-016 SHALL have port dma_rdata  input  DATA_W  DMA read beat data.
REQ-017 SHALL have ports busy/owner  output  1  burst in flight / current owner (0=A, 1=B).
REQ-018 SHALL have ports err  output  1  sticky protocol error; err_clr  input  1  clears err.

Function
REQ-019 SHALL implement FSM IDLE -> ISSUE -> XFER -> IDLE.
REQ-020 In IDLE, with any req high, SHALL pick a winner, latch its addr/len into dma_addr/dma_len, set owner, enter ISSUE next cycle.
REQ-021 Arbitration SHALL be round-robin: with both reqs high, the winner is the requester not served last; a single req wins unconditionally.
REQ-022 In ISSUE, SHALL assert dma_start and the winner's gnt for exactly one cycle, clear the beat counter, and enter XFER.
REQ-023 Latency SHALL be one cycle: req sampled high in IDLE at cycle N gives dma_start/gnt at N+1.
REQ-024 A req dropped before its grant SHALL withdraw with no side effect; a req held high after its gnt SHALL count as a new request.
REQ-025 In XFER, a_rvalid SHALL equal dma_rvalid & owner==0 and b_rvalid SHALL equal dma_rvalid & owner==1, both combinational; rlast SHALL be routed the same way.
REQ-026 The beat counter (LEN_W+1 bits) SHALL increment on each dma_rvalid in XFER.
REQ-027 On dma_rvalid & dma_rlast in XFER, SHALL update the last-served pointer to owner and return to IDLE next cycle.
REQ-028 A new arbitration SHALL be possible in the IDLE cycle that follows, so back-to-back bursts are spaced 2 cycles after rlast.
REQ-029 SHALL set err when:
  - rlast arrives on a beat index != dma_len;
  - the counter exceeds dma_len without rlast;
  - dma_rvalid arrives in IDLE or ISSUE.
REQ-030 On a stray beat (dma_rvalid in IDLE or ISSUE), SHALL route it to neither requester.
REQ-031 A burst with a length error SHALL still terminate only on rlast.
REQ-032 err_clr SHALL clear err; if err_clr coincides with a new error, err SHALL remain set.
REQ-033 busy SHALL be high in ISSUE and XFER; dma_addr, dma_len and owner SHALL be stable from ISSUE through end of XFER.

Reset
REQ-034 On rst high at a clock edge, SHALL enter IDLE; busy=0, owner=0, dma_start=0, a_gnt=b_gnt=0, dma_addr=0, dma_len=0, err=0, beat counter=0.
REQ-035 On reset, the last-served pointer SHALL be B, so A wins the first contention.
REQ-036 rst asserted mid-burst SHALL abort immediately; beats after reset count as stray beats only once rst has deasserted.

Verification
REQ-037 After reset, a_req=b_req=1 with a_len=3, b_len=1 -> a_gnt at cycle 1, 4 beats to A, then b_gnt 2 cycles after A's rlast, 2 beats to B, err=0.
REQ-038 A and B held high continuously for 6 bursts -> grants alternate A,B,A,B,A,B.
REQ-039 b_req only, b_addr=0x1000, b_len=0 -> dma_start=1, dma_addr=0x1000, dma_len=0, owner=1; a single rlast beat -> IDLE.
REQ-040 dma_len=3 with rlast on beat 1 -> err=1, return to IDLE; err_clr pulse -> err=0.
REQ-041 dma_rvalid in IDLE -> err=1, a_rvalid=b_rvalid=0.
REQ-042 rst mid-XFER -> IDLE and busy=0 next cycle; A wins the next contention.
